hamming_uart_link: RTL and testbench
====================================

# hamming_uart_link

Parametrised full-duplex UART link with Hamming(7,4) forward error correction, the next generation of the single-nibble TX/RX top. Each data word of `NIBBLES` nibbles is encoded into `NIBBLES` codewords, which are sent as back-to-back UART frames. A TX word FIFO with a valid/ready handshake decouples the producer from the line. The receiver reassembles and corrects whole words and counts corrected codewords.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be >= 4 and even.
- `NIBBLES`, default 2: nibbles per word; word width W = 4*NIBBLES.
- `FIFO_DEPTH`, default 4: TX word FIFO entries, power of two >= 2.
- `clk`  in  1  single clock; all state on its rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `ena`  in  1  global enable; when 0, all state, including baud counters, holds.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_data`  in  W  word to send.
- `tx_ready`  out  1  FIFO not full; a word is accepted on an edge where `tx_valid & tx_ready & ena`.
- `tx`  out  1  serial line, registered, idles high.
- `tx_busy`  out  1  FSM not IDLE, or FIFO non-empty.
- `rx`  in  1  serial line, asynchronous.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a complete word.
- `rx_data`  out  W  last received corrected word; holds between pulses.
- `rx_corrected`  out  1  qualified by `rx_valid`: at least one codeword in the word had a nonzero syndrome.
- `rx_frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `rx_err_count`  out  8  saturating count of corrected codewords.

## Operation
- Reset values:
  - `tx`=1.
  - `tx_ready`=1 and FIFO empty.
  - `tx_busy`, `rx_valid`, `rx_corrected`, `rx_frame_err` = 0.
  - `rx_data`=0, `rx_err_count`=0.
  - Both FSMs in IDLE.
  - RX synchroniser flops = 1.
- Hamming layout, codeword bit i = position i+1: {c6..c0} = {d3,d2,d1,p3,d0,p2,p1}.
  - p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3.
  - Syndrome {s3,s2,s1} = position of the flipped bit; flip it, then extract the data bits. Double errors are not detected.
- Frame format: start bit (0), then 8 data bits LSB first = {1'b0, codeword}, then stop bit (1). 10 bit times per frame.
- Word order: nibble 0 (`tx_data[3:0]`) is sent first. Within a word, frames run back-to-back with no idle gap.
- TX FSM states: IDLE -> START -> DATA (8 bits) -> STOP.
  - In IDLE with the FIFO non-empty: pop a word, latch it, go to START.
  - After STOP: if nibbles remain, go to START with the next nibble. Otherwise, if the FIFO is non-empty, pop and go to START. Else go to IDLE.
- FIFO: `tx_ready` = !full. A push and a pop on the same edge are both honoured. A push is never accepted when full.
- RX path: two-flop synchroniser, then FSM IDLE -> START -> DATA -> STOP.
  - IDLE: a low synchronised sample starts a half-bit count.
  - START: sample at CLKS_PER_BIT/2. If the sample is high, it is a false start; return to IDLE with no pulse.
  - DATA: sample each bit every CLKS_PER_BIT thereafter. Received bit 7 is ignored.
  - STOP: if the stop sample is 0, pulse `rx_frame_err`, discard the partially assembled word, reset the nibble index, and return to IDLE.
  - Good stop bit: decode and store the nibble at the current index. On the last nibble, pulse `rx_valid` and update `rx_data` and `rx_corrected`.
- `rx_err_count` increments by 1 per codeword with a nonzero syndrome and saturates at 255.

## Timing
- TX start latency: word accepted at edge E into an empty FIFO with TX in IDLE → popped at E+1 → `tx` low from E+2.
- Each bit lasts exactly CLKS_PER_BIT cycles. A word occupies NIBBLES*10*CLKS_PER_BIT cycles.
- `tx_busy` rises at the edge after acceptance. It falls the cycle after the last stop bit completes with the FIFO empty.
- RX latency: `rx_valid` is asserted on the edge after the last frame's mid-stop-bit sample, i.e. 3 cycles after the mid-stop point on the `rx` pin, including the synchroniser.
- `rx_err_count` updates on that same edge for the final codeword. For earlier codewords it updates at their stop-sample edge.
- Reset mid-operation:
  - Next edge forces `tx`=1 and empties the FIFO.
  - RX returns to IDLE with the partial word discarded.
  - All pulses are cleared.
- With `ena`=0 mid-frame, the bit period is stretched by the number of disabled cycles, and no sample is taken during those cycles.

## Test plan
- **Encode/loopback:** NIBBLES=2, CLKS_PER_BIT=4, `tx` looped to `rx`, send 0xA5.
  - Line carries codewords 0x2D then 0x52.
  - `rx_data`=0xA5, `rx_corrected`=0, `rx_err_count`=0.
  - `tx` low exactly 2 cycles after acceptance.
- **Single-bit correction:** send 0xA5 and invert codeword-0 bit 4 on the line.
  - `rx_data`=0xA5, `rx_corrected`=1, `rx_err_count`=1.
  - Repeat 300 times: count stops at 255.
- **FIFO full:** FIFO_DEPTH=4, `tx_valid` held high from idle.
  - Exactly 5 words accepted before `tx_ready` falls, at the edge after the 5th accept.
  - All 5 received in order.
  - `tx_ready` reasserts one cycle after the next pop.
- **Framing error:** drive the 2nd frame's stop bit low.
  - `rx_frame_err` pulses once, no `rx_valid`.
  - The next clean word 0x3C is received correctly.
- **False start:** a 1-cycle low glitch on `rx`.
  - No `rx_valid`, no `rx_frame_err`, RX back in IDLE.
- **Reset mid-frame:** assert `rst_n`=0 during TX DATA bit 3 with 2 words queued.
  - Next edge: `tx`=1, `tx_busy`=0, `tx_ready`=1, `rx_err_count`=0.

Source files
------------

// File: rtl/hamming_uart_link.sv
// Full-duplex UART link carrying Hamming(7,4)-protected words of NIBBLES nibbles.
// TX words queue in a small FIFO; RX corrects single-bit errors per codeword and counts them.
module hamming_uart_link #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NIBBLES      = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   tx_valid,
  input  logic [4*NIBBLES-1:0]   tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  input  logic                   rx,
  output logic                   rx_valid,
  output logic [4*NIBBLES-1:0]   rx_data,
  output logic                   rx_corrected,
  output logic                   rx_frame_err,
  output logic [7:0]             rx_err_count
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Codeword bit i is Hamming position i+1: {d3,d2,d1,p3,d0,p2,p1}.
  function automatic logic [6:0] ham_enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // ---------------- TX word FIFO ----------------
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_push  = ena && tx_valid && !fifo_full;
  assign tx_ready   = !fifo_full;

  // NOTE: reset is sampled synchronously; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  state_t          tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [NW-1:0]   tx_nib_q;
  logic [W-1:0]    tx_word_q;
  logic            tx_q;
  logic            tx_bit_end, tx_last_nib;
  logic [7:0]      tx_byte;

  assign tx_bit_end  = (tx_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign tx_last_nib = (tx_nib_q == NW'(NIBBLES - 1));
  assign tx_byte     = {1'b0, ham_enc(tx_word_q[tx_nib_q*4 +: 4])};
  assign fifo_pop    = ena && !fifo_empty &&
                       ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_bit_end && tx_last_nib));
  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_nib_q   <= '0;
      tx_word_q  <= '0;
      tx_q       <= 1'b1;
    end else if (ena) begin
      unique case (tx_state_q)
        S_IDLE: begin
          tx_q     <= 1'b1;
          tx_cnt_q <= '0;
          if (fifo_pop) begin
            tx_word_q  <= mem_q[rd_ptr_q[AW-1:0]];
            tx_nib_q   <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_DATA: begin
          tx_q <= tx_byte[tx_bit_q];
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_state_q <= S_STOP;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (!tx_last_nib) begin
              tx_nib_q   <= tx_nib_q + 1'b1;
              tx_state_q <= S_START;
            end else if (fifo_pop) begin
              tx_word_q  <= mem_q[rd_ptr_q[AW-1:0]];
              tx_nib_q   <= '0;
              tx_state_q <= S_START;
            end else tx_state_q <= S_IDLE;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic            rx_s1_q, rx_s2_q;
  state_t          rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [6:0]      rx_shift_q;
  logic [NW-1:0]   rx_nib_q;
  logic [W-1:0]    rx_word_q, rx_word_d, rx_data_q;
  logic            rx_acc_q, rx_valid_q, rx_corr_q, rx_ferr_q;
  logic [7:0]      rx_errs_q;
  logic [2:0]      rx_syn;
  logic [6:0]      rx_fixed;
  logic [3:0]      rx_nib;
  logic            rx_half_end, rx_bit_end, rx_last_nib;

  assign rx_half_end = (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign rx_bit_end  = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign rx_last_nib = (rx_nib_q == NW'(NIBBLES - 1));
  assign rx_syn = {rx_shift_q[3] ^ rx_shift_q[4] ^ rx_shift_q[5] ^ rx_shift_q[6],
                   rx_shift_q[1] ^ rx_shift_q[2] ^ rx_shift_q[5] ^ rx_shift_q[6],
                   rx_shift_q[0] ^ rx_shift_q[2] ^ rx_shift_q[4] ^ rx_shift_q[6]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_fixed = rx_shift_q;
    if (rx_syn != 3'd0) rx_fixed[rx_syn - 3'd1] = ~rx_shift_q[rx_syn - 3'd1];
    rx_nib    = {rx_fixed[6], rx_fixed[5], rx_fixed[4], rx_fixed[2]};
    rx_word_d = rx_word_q;
    rx_word_d[rx_nib_q*4 +: 4] = rx_nib;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else if (ena) begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_nib_q   <= '0;
      rx_word_q  <= '0;
      rx_acc_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_corr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_errs_q  <= '0;
    end else if (ena) begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      unique case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_half_end) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q <= '0;
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q != 3'd7) rx_shift_q[rx_bit_q] <= rx_s2_q;
            else                  rx_state_q <= S_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            if (!rx_s2_q) begin
              rx_ferr_q <= 1'b1;
              rx_nib_q  <= '0;
              rx_acc_q  <= 1'b0;
            end else begin
              if (rx_syn != 3'd0 && rx_errs_q != 8'hFF) rx_errs_q <= rx_errs_q + 1'b1;
              rx_word_q <= rx_word_d;
              if (rx_last_nib) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_word_d;
                rx_corr_q  <= rx_acc_q || (rx_syn != 3'd0);
                rx_acc_q   <= 1'b0;
                rx_nib_q   <= '0;
              end else begin
                rx_acc_q <= rx_acc_q || (rx_syn != 3'd0);
                rx_nib_q <= rx_nib_q + 1'b1;
              end
            end
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_corrected = rx_corr_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_err_count = rx_errs_q;

endmodule

// File: tb/tb_hamming_uart_link.sv
// Randomised self-checking bench for hamming_uart_link: loopback, injected errors,
// FIFO back-pressure, framing/false-start handling, enable stretching and mid-frame reset.
module tb_hamming_uart_link;
  localparam int CPB   = 4;
  localparam int NIB   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, tx, tx_busy;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;
  logic       rx_valid, rx_corrected, rx_frame_err;
  logic [7:0] rx_data, rx_err_count;

  assign rx_line = loop ? tx : rx_drv;

  hamming_uart_link #(.CLKS_PER_BIT(CPB), .NIBBLES(NIB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy),
    .rx(rx_line), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_corrected(rx_corrected), .rx_frame_err(rx_frame_err), .rx_err_count(rx_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       corr;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   model_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   ferr_seen = 0;
  logic en_last = 1'b1;
  logic samples [80];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hamming(7,4) from first principles: data fills non-power-of-two positions in order,
  // parity at position 2^j covers every position with bit j set.
  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] cw;
    logic       p;
    int         d;
    cw = '0;
    d  = 0;
    for (int pos = 1; pos <= 7; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = nib[d];
        d++;
      end
    for (int j = 0; j < 3; j++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if ((pos & (1 << j)) != 0 && (pos & (pos - 1)) != 0) p = p ^ cw[pos-1];
      cw[(1 << j) - 1] = p;
    end
    return cw;
  endfunction

  task automatic push_exp(input logic [7:0] d, input int ncorr);
    exp_t e;
    model_cnt += ncorr;
    if (model_cnt > 255) model_cnt = 255;
    e.data = d;
    e.corr = (ncorr != 0);
    e.cnt  = 8'(model_cnt);
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (CPB) tick();
    end
    rx_drv = stop_bit;
    repeat (CPB) tick();
    rx_drv = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [6:0] f0, input logic [6:0] f1,
                           input logic pad, input logic bad_stop1);
    send_frame({pad, enc(w[3:0]) ^ f0}, 1'b1);
    send_frame({1'b0, enc(w[7:4]) ^ f1}, !bad_stop1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("rx_drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) en_last <= ena;

  // Every fresh rx_valid pulse is matched against the head of the expected-word queue.
  always @(negedge clk) begin
    if (rst_n && en_last) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_valid_unexpected: got data=%0h expected no word @%0t", rx_data, $time);
        end else begin
          cur = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(cur.data));
          check("rx_corrected", 32'(rx_corrected), 32'(cur.corr));
          check("rx_err_count", 32'(rx_err_count), 32'(cur.cnt));
        end
      end
      if (rx_frame_err) ferr_seen++;
    end
  end

  initial begin
    logic [7:0] b, want, w;
    logic [6:0] f0, f1;
    int         accepted, base, nc;

    // Reset state
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_corrected", 32'(rx_corrected), 32'd0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_err_count", 32'(rx_err_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Loopback of 0xA5 with exact line timing and codewords
    loop = 1'b1;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    push_exp(8'hA5, 0);
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    check("busy_after_accept", 32'(tx_busy), 32'd1);
    check("tx_high_at_E", 32'(tx), 32'd1);
    tick();
    check("tx_high_at_E1", 32'(tx), 32'd1);
    tick();
    for (int i = 0; i < 80; i++) begin
      samples[i] = tx;
      if (i < 79) tick();
    end
    check("tx_low_at_E2", 32'(samples[0]), 32'd0);
    check("busy_fall", 32'(tx_busy), 32'd0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) b[k] = samples[f*40 + (k+1)*CPB + CPB/2];
      want = (f == 0) ? 8'h2D : 8'h52;
      check("line_start_bit", 32'(samples[f*40 + CPB/2]), 32'd0);
      check("line_codeword", 32'(b), 32'(want));
      check("line_stop_bit", 32'(samples[f*40 + 9*CPB + CPB/2]), 32'd1);
    end
    wait_drain(200);
    check("lb_rx_data", 32'(rx_data), 32'hA5);
    check("lb_rx_corrected", 32'(rx_corrected), 32'd0);
    check("lb_rx_err_count", 32'(rx_err_count), 32'd0);

    // Single-bit correction, then 299 randomised words driving the counter into saturation
    loop = 1'b0;
    repeat (10) tick();
    push_exp(8'hA5, 1);
    send_word(8'hA5, 7'b001_0000, 7'd0, 1'b0, 1'b0);
    repeat (10) tick();
    wait_drain(50);
    check("corr_rx_data", 32'(rx_data), 32'hA5);
    check("corr_rx_corrected", 32'(rx_corrected), 32'd1);
    check("corr_rx_err_count", 32'(rx_err_count), 32'd1);
    for (int i = 1; i < 300; i++) begin
      w  = 8'($urandom);
      f0 = (i % 7 == 3) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
      f1 = ((i % 7 != 3) && ($urandom_range(0, 1) == 1)) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
      nc = ((f0 != 0) ? 1 : 0) + ((f1 != 0) ? 1 : 0);
      push_exp(w, nc);
      send_word(w, f0, f1, (i % 5 == 0), 1'b0);
      repeat ($urandom_range(1, 8)) tick();
    end
    wait_drain(100);
    check("err_count_saturated", 32'(rx_err_count), 32'd255);

    // FIFO back-pressure with tx_valid held high from idle
    loop = 1'b1;
    repeat (5) tick();
    accepted = 0;
    tx_valid = 1'b1;
    for (int c = 0; c < 20 && tx_ready; c++) begin
      tx_data = 8'($urandom);
      push_exp(tx_data, 0);
      accepted++;
      tick();
    end
    tx_valid = 1'b0;
    check("fifo_accepts", 32'(accepted), 32'd5);
    check("fifo_ready_low", 32'(tx_ready), 32'd0);
    repeat (76) tick();
    check("fifo_ready_still_low", 32'(tx_ready), 32'd0);
    tick();
    check("fifo_ready_reassert", 32'(tx_ready), 32'd1);
    wait_drain(5 * 80 + 100);

    // Framing error on the second frame, then a clean word
    loop = 1'b0;
    repeat (10) tick();
    base = ferr_seen;
    send_word(8'h12, 7'd0, 7'd0, 1'b0, 1'b1);
    repeat (20) tick();
    check("frame_err_once", 32'(ferr_seen - base), 32'd1);
    push_exp(8'h3C, 0);
    send_word(8'h3C, 7'd0, 7'd0, 1'b0, 1'b0);
    repeat (10) tick();
    wait_drain(50);
    check("after_ferr_rx_data", 32'(rx_data), 32'h3C);

    // One-cycle glitch is a false start
    base = ferr_seen;
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    check("glitch_no_frame_err", 32'(ferr_seen - base), 32'd0);
    push_exp(8'h5A, 0);
    send_word(8'h5A, 7'd0, 7'd0, 1'b0, 1'b0);
    repeat (10) tick();
    wait_drain(50);
    check("after_glitch_rx_data", 32'(rx_data), 32'h5A);

    // Loopback with ena randomly dropped: the word must survive the stretched bits
    loop = 1'b1;
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    push_exp(8'hC3, 0);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 250; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      tick();
    end
    ena = 1'b1;
    wait_drain(200);

    // Reset during TX DATA bit 3 with two words still queued
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'($urandom);
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    repeat (16) tick();
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    tick();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_err_count", 32'(rx_err_count), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    repeat (120) tick();
    tx_data = 8'h96;
    tx_valid = 1'b1;
    push_exp(8'h96, 0);
    tick();
    tx_valid = 1'b0;
    wait_drain(200);
    check("post_rst_rx_data", 32'(rx_data), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
